ssd_scan_ctrl: RTL and testbench



---
 rtl/ssd_scan_if.sv | 15 +
 rtl/ssd_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Handshake and display bus between the multiplier-side sequencer and the seven-segment scan controller.
interface ssd_scan_if #(
  parameter int W    = 8,
  parameter int NDIG = 3
);
  logic            start;
  logic [W-1:0]    value;
  logic            busy;
  logic            done;
  logic [3:0]      digit_out;
  logic [NDIG-1:0] an;

  modport master (output start, value, input busy, done, digit_out, an);
  modport slave  (input start, value, output busy, done, digit_out, an);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Double-dabble binary-to-BCD converter feeding a time-multiplexed seven-segment scan
// with active-low one-hot digit enables and optional leading-zero blanking.
module ssd_scan_nib (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module ssd_scan_ctrl #(
  parameter int W             = 8,
  parameter int NDIG          = 3,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  ssd_scan_if.slave  bus
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW = 4*NDIG + W;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                state;
  logic                  busy_q, done_q;
  logic [W-1:0]          sh;
  logic [NDIG-1:0][3:0]  bcd, adj, disp, disp_nxt;
  logic [BW-1:0]         bitcnt;
  logic [SW-1:0]         cat_sh;
  logic                  last;

  logic [CW-1:0]         rcnt, rcnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  wrap;
  logic [NDIG-1:0]       blank;
  logic                  zero_above;
  logic [NDIG-1:0]       an_q;
  logic [3:0]            dig_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_nib
    ssd_scan_nib u_nib (.d(bcd[g]), .q(adj[g]));
  end

  assign cat_sh = {adj, sh} << 1;
  assign last   = (bitcnt == BW'(W-1));

  // Final BCD bypasses the display regs so the scan shows new digits in the done cycle.
  assign disp_nxt = (state == S_CONV && last) ? cat_sh[SW-1:W] : disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sh     <= '0;
      bcd    <= '0;
      bitcnt <= '0;
      disp   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            sh     <= bus.value;
            bcd    <= '0;
            bitcnt <= '0;
            busy_q <= 1'b1;
            state  <= S_CONV;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_CONV: begin
          {bcd, sh} <= cat_sh;
          bitcnt    <= bitcnt + 1'b1;
          if (last) begin
            disp   <= cat_sh[SW-1:W];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wrap     = (rcnt == CW'(REFRESH_DIV-1));
  assign rcnt_nxt = wrap ? '0 : rcnt + 1'b1;
  assign idx_nxt  = !wrap ? idx : (idx == IW'(NDIG-1)) ? '0 : idx + 1'b1;

  // A digit above the ones place blanks when it and everything above it is zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NDIG-1; i > 0; i--) begin
      zero_above = zero_above && (disp_nxt[i] == 4'd0);
      blank[i]   = (BLANK_LEADING != 0) && zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt  <= '0;
      idx   <= '0;
      an_q  <= ~NDIG'(1);
      dig_q <= 4'd0;
    end else begin
      rcnt  <= rcnt_nxt;
      idx   <= idx_nxt;
      an_q  <= ~(NDIG'(1) << idx_nxt);
      dig_q <= blank[idx_nxt] ? 4'hF : disp_nxt[idx_nxt];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.an        = an_q;
  assign bus.digit_out = dig_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised bench for ssd_scan_ctrl: two instances (blanking/div 4, no blanking/div 3)
// share stimulus and are checked against a decimal-arithmetic display model.
module tb_ssd_scan_ctrl;
  localparam int W = 8, NDIG = 3, DIV0 = 4, DIV1 = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] value = '0;
  int n_cmp = 0, n_err = 0, ticks = 0, disp_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= rst ? 0 : ticks + 1;

  ssd_scan_if #(.W(W), .NDIG(NDIG)) if0 ();
  ssd_scan_if #(.W(W), .NDIG(NDIG)) if1 ();
  assign if0.start = start;
  assign if0.value = value;
  assign if1.start = start;
  assign if1.value = value;

  ssd_scan_ctrl #(.W(W), .NDIG(NDIG), .REFRESH_DIV(DIV0), .BLANK_LEADING(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ssd_scan_ctrl #(.W(W), .NDIG(NDIG), .REFRESH_DIV(DIV1), .BLANK_LEADING(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  function automatic logic [NDIG-1:0] exp_an(int i);
    logic [NDIG-1:0] a;
    a    = '1;
    a[i] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_dig(int val, int i, bit blank);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (blank && i > 0 && val < p) return 4'hF;
    return 4'((val / p) % 10);
  endfunction

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); rst = 1'b0; disp_exp = 0;
    n_cmp++; if (if0.busy !== 1'b0 || if1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b/%b want 0", if0.busy, if1.busy); end
    n_cmp++; if (if0.done !== 1'b0 || if1.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b/%b want 0", if0.done, if1.done); end
    n_cmp++; if (if0.an !== 3'b110 || if1.an !== 3'b110) begin n_err++; $display("FAIL reset_an got %b/%b want 110", if0.an, if1.an); end
    n_cmp++; if (if0.digit_out !== 4'd0 || if1.digit_out !== 4'd0) begin n_err++; $display("FAIL reset_digit got %h/%h want 0", if0.digit_out, if1.digit_out); end
  endtask

  // Starts a conversion at the current falling edge; returns at the falling edge `hold` cycles after done.
  task automatic convert(input int v, input int hold);
    int i0, i1;
    start = 1'b1; value = W'(v);
    @(negedge clk);
    for (int c = 1; c <= W + 1 + hold; c++) begin
      if (c == W + 1) disp_exp = v;
      n_cmp++; if (if0.busy !== (c <= W) || if1.busy !== (c <= W)) begin n_err++; $display("FAIL conv_busy v=%0d cyc=%0d got %b/%b want %b", v, c, if0.busy, if1.busy, c <= W); end
      n_cmp++; if (if0.done !== (c == W + 1) || if1.done !== (c == W + 1)) begin n_err++; $display("FAIL conv_done v=%0d cyc=%0d got %b/%b want %b", v, c, if0.done, if1.done, c == W + 1); end
      i0 = (ticks / DIV0) % NDIG; i1 = (ticks / DIV1) % NDIG;
      n_cmp++; if (if0.an !== exp_an(i0) || if0.digit_out !== exp_dig(disp_exp, i0, 1)) begin n_err++; $display("FAIL scan0 v=%0d cyc=%0d got an=%b dig=%h want an=%b dig=%h", v, c, if0.an, if0.digit_out, exp_an(i0), exp_dig(disp_exp, i0, 1)); end
      n_cmp++; if (if1.an !== exp_an(i1) || if1.digit_out !== exp_dig(disp_exp, i1, 0)) begin n_err++; $display("FAIL scan1 v=%0d cyc=%0d got an=%b dig=%h want an=%b dig=%h", v, c, if1.an, if1.digit_out, exp_an(i1), exp_dig(disp_exp, i1, 0)); end
      if (c <= W) begin start = 1'(($urandom % 2)); value = W'($urandom); end
      else start = 1'b0;
      if (c < W + 1 + hold) @(negedge clk);
    end
  endtask

  task automatic test_scan();
    int i0, i1;
    convert(225, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      i0 = (ticks / DIV0) % NDIG; i1 = (ticks / DIV1) % NDIG;
      n_cmp++; if (if0.an !== exp_an(i0) || if0.digit_out !== exp_dig(225, i0, 1)) begin n_err++; $display("FAIL scan_hold0 t=%0d got an=%b dig=%h want an=%b dig=%h", ticks, if0.an, if0.digit_out, exp_an(i0), exp_dig(225, i0, 1)); end
      n_cmp++; if (if1.an !== exp_an(i1) || if1.digit_out !== exp_dig(225, i1, 0)) begin n_err++; $display("FAIL scan_hold1 t=%0d got an=%b dig=%h want an=%b dig=%h", ticks, if1.an, if1.digit_out, exp_an(i1), exp_dig(225, i1, 0)); end
    end
  endtask

  task automatic test_blanking();
    convert(7, 12);
    convert(0, 12);
    convert(105, 12);
    convert(100, 12);
  endtask

  task automatic test_back_to_back();
    int i0;
    bit bz, dn;
    start = 1'b1; value = 8'd99;
    @(negedge clk);
    for (int c = 1; c <= 18; c++) begin
      bz = (c <= 8) || (c >= 10 && c <= 17);
      dn = (c == 9) || (c == 18);
      if (c == 9) disp_exp = 99;
      if (c == 18) disp_exp = 255;
      n_cmp++; if (if0.busy !== bz || if0.done !== dn) begin n_err++; $display("FAIL b2b cyc=%0d got busy=%b done=%b want busy=%b done=%b", c, if0.busy, if0.done, bz, dn); end
      i0 = (ticks / DIV0) % NDIG;
      n_cmp++; if (if0.digit_out !== exp_dig(disp_exp, i0, 1)) begin n_err++; $display("FAIL b2b_digit cyc=%0d got %h want %h", c, if0.digit_out, exp_dig(disp_exp, i0, 1)); end
      start = (c == 3) || (c == 9);
      value = 8'd255;
      if (c < 18) @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int i0, i1;
    convert(123, 2);
    start = 1'b1; value = 8'd200;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; disp_exp = 0;
    n_cmp++; if (if0.an !== 3'b110 || if0.digit_out !== 4'd0 || if0.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid got an=%b dig=%h busy=%b want 110 0 0", if0.an, if0.digit_out, if0.busy); end
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      i0 = (ticks / DIV0) % NDIG; i1 = (ticks / DIV1) % NDIG;
      n_cmp++; if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if1.done !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle c=%0d got done=%b busy=%b want 0 0", c, if0.done, if0.busy); end
      n_cmp++; if (if0.digit_out !== exp_dig(0, i0, 1) || if1.digit_out !== exp_dig(0, i1, 0)) begin n_err++; $display("FAIL rst_mid_disp c=%0d got %h/%h want %h/%h", c, if0.digit_out, if1.digit_out, exp_dig(0, i0, 1), exp_dig(0, i1, 0)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 6)));
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) convert(v, 12);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
